// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Also holds the one-hot-to-index helper used when a grant is released.
package uart_tx_arbiter_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} uart_arb_state_t;

   localparam int UART_ARB_MAX_REQ = 8;
   localparam int UART_ARB_IDX_W   = $clog2(UART_ARB_MAX_REQ);

   // OR of the indices of set bits; exact for a one-hot input.
   function automatic logic [UART_ARB_IDX_W-1:0] onehot_to_idx(input logic [UART_ARB_MAX_REQ-1:0] oh);
      logic [UART_ARB_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < UART_ARB_MAX_REQ; i++) begin
         if (oh[i]) idx = idx | UART_ARB_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side byte handshake bundle for uart_tx_arbiter.
// Signal suffixes are from the arbiter's point of view.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0][7:0] req_data_i;
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ-1:0]      req_last_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic [NUM_REQ-1:0]      grant_o;
   logic [7:0]              tx_data_o;
   logic                    tx_valid_o;
   logic                    tx_ready_i;
   logic                    timeout_o;

   modport slave (
      input  req_data_i, req_valid_i, req_last_i, tx_ready_i,
      output req_ready_o, grant_o, tx_data_o, tx_valid_o, timeout_o
   );

   modport master (
      output req_data_i, req_valid_i, req_last_i, tx_ready_i,
      input  req_ready_o, grant_o, tx_data_o, tx_valid_o, timeout_o
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr_i,
// wrapping modulo NUM_REQ. Generic enough for other bus arbiters.
module uart_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic               any_req_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      pick_o = '0;
      found  = 1'b0;
      cand   = '0;
      // Offset NUM_REQ lands back on rr_ptr_i itself, so it is checked last.
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(rr_ptr_i) + off) % NUM_REQ);
         if (!found && req_i[cand]) begin
            pick_o[cand] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters, with a registered byte output stage.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic               clk_i,
   input logic               reset_i,
   uart_tx_arbiter_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   uart_arb_state_t    state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic               tx_valid_q, tx_valid_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               timeout_q, timeout_d;

   logic [NUM_REQ-1:0] pick;
   logic               any_req;
   logic               out_free;
   logic               owner_valid;
   logic               owner_last;
   logic [7:0]         owner_data;
   logic [IDX_W-1:0]   owner_idx;
   logic               accept;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i     (bus.req_valid_i),
      .rr_ptr_i  (rr_ptr_q),
      .pick_o    (pick),
      .any_req_o (any_req)
   );

   // Output register can take a byte when empty or draining this cycle.
   assign out_free        = !tx_valid_q || bus.tx_ready_i;
   assign bus.req_ready_o = grant_q & {NUM_REQ{out_free}};

   always_comb begin
      owner_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) owner_data = owner_data | bus.req_data_i[i];
      end
   end

   assign owner_valid = |(grant_q & bus.req_valid_i);
   assign owner_last  = |(grant_q & bus.req_last_i);
   assign owner_idx   = IDX_W'(onehot_to_idx(UART_ARB_MAX_REQ'(grant_q)));
   assign accept      = owner_valid && out_free;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      timeout_d  = 1'b0;
      tx_valid_d = tx_valid_q && !bus.tx_ready_i;
      tx_data_d  = tx_data_q;

      case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               grant_d    = pick;
               state_d    = ARB_LOCKED;
               idle_cnt_d = '0;
            end
         end
         ARB_LOCKED: begin
            if (accept) begin
               tx_valid_d = 1'b1;
               tx_data_d  = owner_data;
               idle_cnt_d = '0;
               if (owner_last) begin
                  state_d  = ARB_IDLE;
                  grant_d  = '0;
                  rr_ptr_d = owner_idx;
               end
            end else if (!owner_valid) begin
               // This idle cycle is the TIMEOUT_CYCLES-th one: release now.
               if (idle_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_d  = 1'b1;
                  state_d    = ARB_IDLE;
                  grant_d    = '0;
                  rr_ptr_d   = owner_idx;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
         idle_cnt_q <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.grant_o    = grant_q;
   assign bus.tx_valid_o = tx_valid_q;
   assign bus.tx_data_o  = tx_data_q;
   assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level reference model of
// owners, output byte and idle time, checked every cycle on the falling edge.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

   uart_tx_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit started     = 0;

   // Per-requester pending bytes: {last, data}; head is what is offered.
   logic [8:0] q[NR][$];

   // Reference model state.
   int         m_owner = -1;
   int         m_rr    = NR - 1;
   int         m_idle  = 0;
   int         m_k     = 0;
   bit         m_txv   = 0;
   bit         m_to    = 0;
   bit         m_room  = 0;
   logic [7:0] m_txd   = 8'h00;

   typedef struct {logic [7:0] data; int cyc;} dl_t;
   dl_t        dlog[$];
   int         glog[$];
   logic [7:0] exp_q[$];
   int         exp_g[$];
   int         to_count = 0;
   int         to_cyc   = -1;
   logic [NR-1:0] to_grant = '0;
   logic [NR-1:0] prev_grant = '0;
   int         rise_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input bit last);
      q[r].push_back({last, d});
   endtask

   function automatic bit model_idle();
      bit e;
      e = (m_owner < 0) && !m_txv;
      for (int i = 0; i < NR; i++) if (q[i].size() != 0) e = 0;
      return e;
   endfunction

   function automatic logic [31:0] dl_data(input int i);
      return (i < dlog.size()) ? 32'(dlog[i].data) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] dl_cyc(input int i);
      return (i < dlog.size()) ? 32'(dlog[i].cyc) : 32'hFFFF_FFFF;
   endfunction

   task automatic run_until_idle(input string name, input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(posedge clk); #2;
         if (model_idle()) done = 1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, max_cyc);
      end
   endtask

   task automatic wait_loaded(input string name, input int k, input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(posedge clk); #2;
         if (m_owner == k && m_txv) done = 1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: requester %0d never loaded a byte within %0d cycles", name, k, max_cyc);
      end
   endtask

   task automatic check_log(input string name);
      check({name, "_count"}, dlog.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), dl_data(i), 32'(exp_q[i]));
   endtask

   task automatic check_grants(input string name);
      check({name, "_grant_count"}, glog.size(), exp_g.size());
      for (int i = 0; i < exp_g.size(); i++)
         check($sformatf("%s_grant%0d", name, i), (i < glog.size()) ? glog[i] : -1, exp_g[i]);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_grant"}, bus.grant_o, 0);
      check({name, "_ready"}, bus.req_ready_o, 0);
      check({name, "_tx_valid"}, bus.tx_valid_o, 0);
      check({name, "_tx_data"}, bus.tx_data_o, 0);
      check({name, "_timeout"}, bus.timeout_o, 0);
   endtask

   // Requester behaviour: offer the queue head until the model sees it taken.
   initial forever begin
      for (int i = 0; i < NR; i++) begin
         if (q[i].size() > 0) begin
            bus.req_valid_i[i] = 1'b1;
            bus.req_data_i[i]  = q[i][0][7:0];
            bus.req_last_i[i]  = q[i][0][8];
         end else begin
            bus.req_valid_i[i] = 1'b0;
            bus.req_data_i[i]  = 8'h00;
            bus.req_last_i[i]  = 1'b0;
         end
      end
      @(posedge clk); #3;
   end

   // Reference model, advanced on every rising edge.
   initial forever begin
      @(posedge clk);
      cyc++;
      started = 1;
      if (!reset_i) begin
         m_owner = -1;
         m_rr    = NR - 1;
         m_idle  = 0;
         m_txv   = 0;
         m_txd   = 8'h00;
         m_to    = 0;
      end else begin
         m_room = !m_txv || bus.tx_ready_i;
         if (m_txv && bus.tx_ready_i) m_txv = 0;
         m_to = 0;
         if (m_owner < 0) begin
            for (int off = 1; off <= NR; off++) begin
               m_k = (m_rr + off) % NR;
               if (bus.req_valid_i[m_k]) begin
                  m_owner = m_k;
                  break;
               end
            end
         end else begin
            m_k = m_owner;
            if (bus.req_valid_i[m_k] && m_room) begin
               m_txv  = 1;
               m_txd  = bus.req_data_i[m_k];
               m_idle = 0;
               void'(q[m_k].pop_front());
               if (bus.req_last_i[m_k]) begin
                  m_rr    = m_k;
                  m_owner = -1;
               end
            end else if (!bus.req_valid_i[m_k]) begin
               m_idle++;
               if (m_idle >= TO) begin
                  m_to    = 1;
                  m_rr    = m_k;
                  m_owner = -1;
                  m_idle  = 0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison and transaction logging on the falling edge.
   initial forever begin
      logic [NR-1:0] eg;
      int            gidx;
      @(negedge clk);
      if (started) begin
         eg = '0;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         check("grant_o", bus.grant_o, eg);
         check("req_ready_o", bus.req_ready_o, (!m_txv || bus.tx_ready_i) ? eg : '0);
         check("tx_valid_o", bus.tx_valid_o, m_txv);
         check("tx_data_o", bus.tx_data_o, m_txd);
         check("timeout_o", bus.timeout_o, m_to);

         if (reset_i && bus.tx_valid_o && bus.tx_ready_i) begin
            dlog.push_back('{bus.tx_data_o, cyc});
            $display("tx byte %02h at cycle %0d", bus.tx_data_o, cyc);
         end
         if (bus.timeout_o) begin
            to_count++;
            to_cyc   = cyc;
            to_grant = bus.grant_o;
         end
         if (bus.grant_o != '0 && prev_grant == '0) begin
            gidx = -1;
            for (int i = 0; i < NR; i++) if (bus.grant_o[i]) gidx = i;
            glog.push_back(gidx);
         end
         prev_grant = bus.grant_o;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b0;
      bus.tx_ready_i = 1'b1;

      // Single requester 0 sends a 3-byte packet at full throughput.
      @(posedge clk); #2;
      push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #2;
      reset_i = 1'b1;
      rise_cyc = cyc;
      run_until_idle("t1_wait", 50);
      exp_q = '{8'h41, 8'h42, 8'h43};
      check_log("t1");
      check("t1_first_latency", dl_cyc(0) - rise_cyc, 2);
      check("t1_second_cycle", dl_cyc(1) - rise_cyc, 3);
      check("t1_third_cycle", dl_cyc(2) - rise_cyc, 4);
      check("t1_grant_released", bus.grant_o, 0);

      // Requesters 0 and 1 both valid at reset exit, two packets each.
      reset_i = 1'b0;
      push(0, 8'h10, 0); push(0, 8'h11, 1); push(0, 8'h12, 0); push(0, 8'h13, 1);
      push(1, 8'h20, 0); push(1, 8'h21, 1); push(1, 8'h22, 0); push(1, 8'h23, 1);
      @(posedge clk); #2;
      reset_i = 1'b1;
      dlog.delete(); glog.delete();
      run_until_idle("t2_wait", 100);
      exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
      check_log("t2");
      exp_g = '{0, 1, 0, 1};
      check_grants("t2");
      check("t2_back_to_back", dl_cyc(1) - dl_cyc(0), 1);
      check("t2_release_bubble", dl_cyc(2) - dl_cyc(1), 2);

      // Backpressure for 10 cycles mid-packet: no timeout, output held.
      dlog.delete(); to_count = 0;
      push(0, 8'h30, 0); push(0, 8'h31, 0); push(0, 8'h32, 1);
      wait_loaded("t3_load", 0, 20);
      bus.tx_ready_i = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check("t3_data_held", bus.tx_data_o, 8'h30);
      check("t3_valid_held", bus.tx_valid_o, 1);
      check("t3_ready_low", bus.req_ready_o, 0);
      check("t3_grant_kept", bus.grant_o, 4'b0001);
      check("t3_no_timeout", to_count, 0);
      bus.tx_ready_i = 1'b1;
      run_until_idle("t3_wait", 50);
      exp_q = '{8'h30, 8'h31, 8'h32};
      check_log("t3");
      check("t3_no_timeout_end", to_count, 0);

      // Requester 1 sends one non-last byte then goes quiet; requester 0 waits.
      dlog.delete(); glog.delete(); to_count = 0; to_cyc = -1;
      push(1, 8'h40, 0);
      push(0, 8'h50, 1);
      run_until_idle("t4_wait", 100);
      exp_q = '{8'h40, 8'h50};
      check_log("t4");
      exp_g = '{1, 0};
      check_grants("t4");
      check("t4_timeout_pulses", to_count, 1);
      check("t4_timeout_delay", to_cyc - int'(dl_cyc(0)), TO);
      check("t4_grant_at_timeout", to_grant, 0);
      check("t4_next_after_bubble", dl_cyc(1) - to_cyc, 2);

      // Reset pulse in the middle of requester 2's packet.
      push(2, 8'h60, 0); push(2, 8'h61, 0); push(2, 8'h62, 1);
      wait_loaded("t5_load", 2, 20);
      reset_i = 1'b0;
      for (int i = 0; i < NR; i++) q[i].delete();
      @(posedge clk); #2;
      check_reset_outputs("t5_reset");
      reset_i = 1'b1;
      dlog.delete(); glog.delete();
      push(1, 8'h81, 1);
      push(0, 8'h80, 1);
      run_until_idle("t5_wait", 50);
      exp_q = '{8'h80, 8'h81};
      check_log("t5");
      exp_g = '{0, 1};
      check_grants("t5");

      // All four requesters valid with single-byte packets: rotation 0,1,2,3,0.
      reset_i = 1'b0;
      push(0, 8'h90, 1); push(0, 8'h94, 1);
      push(1, 8'h91, 1); push(2, 8'h92, 1); push(3, 8'h93, 1);
      @(posedge clk); #2;
      reset_i = 1'b1;
      dlog.delete(); glog.delete();
      run_until_idle("t6_wait", 100);
      exp_q = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
      check_log("t6");
      exp_g = '{0, 1, 2, 3, 0};
      check_grants("t6");
      for (int i = 1; i < 5; i++)
         check($sformatf("t6_spacing%0d", i), dl_cyc(i) - dl_cyc(i - 1), 2);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
